// File: rtl/mem_dpi_bus.sv
// Handshaked pmem port: one outstanding request, memory access performed once at the
// acceptance edge, response presented LATENCY cycles later and held until taken.
module mem_dpi_bus #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned MODEL_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       addr_lo;
  logic [31:0]       addr_hi;
  logic [63:0]       wdata64;
  logic [7:0]        wmask8;
  logic              aligned;
  logic              accept;

  assign addr_lo   = 32'(req_addr);
  assign addr_hi   = addr_lo + 32'd4;
  assign wdata64   = 64'(req_wdata);
  assign wmask8    = 8'(req_wmask);
  assign aligned   = (req_addr[OFF_W-1:0] == '0);
  assign accept    = (state == IDLE) && req_valid;
  assign rsp_rdata = rsp_valid ? data_q : '0;

  // WAIT exits on the edge that takes cnt to 0, so rsp_valid rises LATENCY cycles
  // after acceptance; LATENCY == 1 has no WAIT cycle at all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt       <= 4'(LATENCY - 1);
            err_q     <= !aligned;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= !aligned;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stand-alone backing store with the same call semantics as pmem, plus call counters.
  localparam int unsigned IDX_W = $clog2(MODEL_WORDS);

  logic [31:0]      mem [MODEL_WORDS];
  logic [31:0]      pmem_rd_calls;
  logic [31:0]      pmem_wr_calls;
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] idx_hi;

  assign idx_lo = IDX_W'(addr_lo >> 2);
  assign idx_hi = IDX_W'(addr_hi >> 2);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    merge = old;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q        <= '0;
      pmem_rd_calls <= '0;
      pmem_wr_calls <= '0;
    end else if (accept) begin
      data_q <= '0;
      if (aligned && req_wen) begin
        if (wmask8[3:0] != 4'h0)
          mem[idx_lo] <= merge(mem[idx_lo], wdata64[31:0], wmask8[3:0]);
        if (DATA_W == 64 && wmask8[7:4] != 4'h0)
          mem[idx_hi] <= merge(mem[idx_hi], wdata64[63:32], wmask8[7:4]);
        pmem_wr_calls <= pmem_wr_calls + 32'(wmask8[3:0] != 4'h0)
                       + 32'((DATA_W == 64) && (wmask8[7:4] != 4'h0));
      end else if (aligned) begin
        data_q        <= DATA_W'({mem[idx_hi], mem[idx_lo]});
        pmem_rd_calls <= pmem_rd_calls + ((DATA_W == 64) ? 32'd2 : 32'd1);
      end
    end
  end

endmodule

// File: doc/mem_dpi_bus.md
Name: mem_dpi_bus

Overview:
- Sequential, handshaked successor to the combinational DPI memory port in the NPC simulation environment.
- Accepts one request at a time on a valid/ready request channel and performs the access through DPI-C pmem_read/pmem_write.
- Returns the result on a valid/ready response channel after a configurable latency.
- Used by IFU/LSU to model non-zero memory latency and back-pressure; adds misalignment error reporting and 64-bit data width.

Parameters:
- ADDR_W, 32, address width; only the low 32 bits are passed to DPI.
- DATA_W, 32, data width; legal values are 32 or 64.
- LATENCY, 1, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  DATA_W/8  byte write enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  misaligned access.

Behaviour:
- Reset: rst_n is sampled at posedge clk. While low: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- Reset mid-operation aborts any pending response. A write already issued to DPI is not undone.
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: counting down.
  - RESP: rsp_valid = 1.
- IDLE -> WAIT on req_valid & req_ready at a posedge:
  - Capture wen, address and data; load counter with LATENCY-1.
  - If LATENCY == 1, go directly to RESP on that edge.
- WAIT: decrement counter each cycle. On the edge where the counter is 0, go to RESP.
- RESP: rsp_valid held with rsp_rdata/rsp_err stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake, so there is no same-cycle turnaround.
- Total latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge, assuming no back-pressure.
- req_ready = 1 only in IDLE. The block has at most one outstanding transaction.
- Alignment check: address bits [log2(DATA_W/8)-1:0] must be 0. If misaligned:
  - No DPI call is made.
  - The response carries rsp_err = 1 and rsp_rdata = 0, with the same latency.
- DPI access is performed once, in the sequential block, at the acceptance edge. It is never performed combinationally and never repeated while waiting.
  - Read, DATA_W = 32: rdata = pmem_read(addr).
  - Read, DATA_W = 64: low word = pmem_read(addr); high word = pmem_read(addr+4).
  - Write: pmem_write(addr, wdata[31:0], {4'b0, wmask[3:0]}), called only if wmask[3:0] != 0.
  - Write, DATA_W = 64: additionally pmem_write(addr+4, wdata[63:32], {4'b0, wmask[7:4]}), called only if wmask[7:4] != 0.
  - Address arithmetic for addr+4 is 32-bit and wraps at 2^32.
- Write with all-zero wmask: completes normally with rsp_err = 0 and no DPI call.
- Read-after-write ordering is guaranteed, because the write is committed to pmem at its acceptance edge, before any later request is accepted.
- Write responses return rsp_rdata = 0.
- Inputs are ignored outside IDLE; req_* may change freely while req_ready = 0.

Test Plan:
- LATENCY = 3, DATA_W = 32; write addr 0x80000000, wdata 0xDEADBEEF, wmask 0xF, then read the same address -> each rsp_valid rises 3 cycles after acceptance; read rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte-masked write of 0x11223344 with wmask 0x2 over 0xDEADBEEF, then read -> 0xDEAD33EF.
- Misaligned read at 0x80000002 -> rsp_err = 1, rsp_rdata = 0, no pmem_read call (checked by DPI call counter), latency unchanged.
- Back-pressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready = 0, a second req_valid is not accepted; it is accepted the cycle after rsp_ready = 1.
- DATA_W = 64; write at 0x80000008 with wmask 0xF0, wdata 0xAABBCCDD_00000000 -> only one pmem_write, at 0x8000000C; 64-bit readback high word = 0xAABBCCDD.
- rst_n low for one cycle while in WAIT -> next cycle rsp_valid = 0, req_ready = 1, and no stale response appears afterwards.
